baud_gen_frac: RTL and testbench

BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

---
 rtl/baud_gen_frac.sv | 158 +++++++++++++++
 tb/tb_baud_gen_frac.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/baud_gen_frac.sv
// Fractional-N baud generator: oversample strobe plus TX bit and RX mid-bit strobes.
// Define BAUD_GEN_FRAC_EN to enable the sixteenths accumulator; otherwise the period is the integer divisor.
module baud_gen_frac #(
  parameter int DIV_W    = 16,
  parameter int OSR      = 16,
  parameter int DEF_INT  = 6,
  parameter int DEF_FRAC = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div_int,
  input  logic [3:0]       cfg_div_frac,
  output logic             cfg_err,
  input  logic             rx_resync,
  output logic             samp_tick,
  output logic             baud_tick_tx,
  output logic             baud_tick_rx
);

  localparam int PH_W  = $clog2(OSR);
  localparam int CNT_W = DIV_W + 1;
  localparam logic [PH_W-1:0] LAST_PH = PH_W'(OSR - 1);
  localparam logic [PH_W-1:0] MID_PH  = PH_W'(OSR / 2 - 1);

  function automatic logic [CNT_W-1:0] period_of(input logic [DIV_W-1:0] div, input logic carry);
    return {1'b0, div} + CNT_W'(carry);
  endfunction

  function automatic logic [PH_W-1:0] phase_inc(input logic [PH_W-1:0] ph);
    return (ph == LAST_PH) ? '0 : ph + PH_W'(1);
  endfunction

  logic [CNT_W-1:0] cnt, cnt_nx, period, period_nx;
  logic [PH_W-1:0]  tx_phase, tx_nx, rx_phase, rx_nx;
  logic [DIV_W-1:0] act_int, act_int_nx, new_int, pend_int, pend_int_nx;
  logic             pend, pend_nx, run, tick_now, apply, carry;
  logic             samp_nx, btx_nx, brx_nx, err_nx;

  assign pend = ~cfg_ready;

`ifdef BAUD_GEN_FRAC_EN
  logic [3:0] acc, acc_nx, acc_sum, act_frac, act_frac_nx, new_frac, pend_frac, pend_frac_nx;
`else
  logic unused_frac;
  assign unused_frac = ^{cfg_div_frac, 4'(DEF_FRAC)};
`endif

  always_comb begin
    tick_now    = run && (cnt == period - CNT_W'(1));
    apply       = pend && (!en || tick_now);
    new_int     = apply ? pend_int : act_int;
`ifdef BAUD_GEN_FRAC_EN
    new_frac    = apply ? pend_frac : act_frac;
    {carry, acc_sum} = {1'b0, acc} + {1'b0, new_frac};
    acc_nx      = acc;
    act_frac_nx = new_frac;
    pend_frac_nx = pend_frac;
`else
    carry       = 1'b0;
`endif
    cnt_nx      = cnt;
    period_nx   = period;
    tx_nx       = tx_phase;
    rx_nx       = rx_phase;
    act_int_nx  = new_int;
    pend_nx     = pend && !apply;
    pend_int_nx = pend_int;

    if (!en) begin
      cnt_nx    = '0;
      tx_nx     = '0;
      rx_nx     = '0;
      period_nx = period_of(new_int, 1'b0);
`ifdef BAUD_GEN_FRAC_EN
      acc_nx    = '0;
`endif
    end else if (!run) begin
      // First enabled cycle counts as cnt==0 so the first strobe lands div_int cycles after en rises.
      cnt_nx = '0;
    end else if (tick_now) begin
      cnt_nx    = '0;
      tx_nx     = phase_inc(tx_phase);
      rx_nx     = phase_inc(rx_phase);
      period_nx = period_of(new_int, carry);
`ifdef BAUD_GEN_FRAC_EN
      acc_nx    = acc_sum;
`endif
    end else begin
      cnt_nx = cnt + CNT_W'(1);
    end

    if (en && rx_resync) begin
      cnt_nx = '0;
      rx_nx  = '0;
    end

    err_nx = cfg_valid && cfg_ready && (cfg_div_int < DIV_W'(2));
    if (cfg_valid && cfg_ready && !err_nx) begin
      pend_nx     = 1'b1;
      pend_int_nx = cfg_div_int;
`ifdef BAUD_GEN_FRAC_EN
      pend_frac_nx = cfg_div_frac;
`endif
    end

    // Strobes are registered: decide now whether the next cycle is the last of its period.
    samp_nx = en && (cnt_nx == period_nx - CNT_W'(1));
    btx_nx  = samp_nx && (tx_nx == LAST_PH);
    brx_nx  = samp_nx && (rx_nx == MID_PH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      period       <= period_of(DIV_W'(DEF_INT), 1'b0);
      tx_phase     <= '0;
      rx_phase     <= '0;
      act_int      <= DIV_W'(DEF_INT);
      run          <= 1'b0;
      cfg_ready    <= 1'b1;
      cfg_err      <= 1'b0;
      samp_tick    <= 1'b0;
      baud_tick_tx <= 1'b0;
      baud_tick_rx <= 1'b0;
`ifdef BAUD_GEN_FRAC_EN
      acc          <= '0;
      act_frac     <= 4'(DEF_FRAC);
`endif
    end else begin
      cnt          <= cnt_nx;
      period       <= period_nx;
      tx_phase     <= tx_nx;
      rx_phase     <= rx_nx;
      act_int      <= act_int_nx;
      run          <= en;
      cfg_ready    <= !pend_nx;
      cfg_err      <= err_nx;
      samp_tick    <= samp_nx;
      baud_tick_tx <= btx_nx;
      baud_tick_rx <= brx_nx;
`ifdef BAUD_GEN_FRAC_EN
      acc          <= acc_nx;
      act_frac     <= act_frac_nx;
`endif
    end
  end

  always_ff @(posedge clk) begin
    pend_int  <= pend_int_nx;
`ifdef BAUD_GEN_FRAC_EN
    pend_frac <= pend_frac_nx;
`endif
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Scoreboard bench for baud_gen_frac: stimulus queues expected strobe cycles, a negedge monitor pops and compares.
module tb_baud_gen_frac;

  localparam int DIV_W = 16;
`ifdef BAUD_GEN_FRAC_EN
  localparam bit FRAC = 1'b1;
`else
  localparam bit FRAC = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0, en = 1'b0, cfg_valid = 1'b0, rx_resync = 1'b0;
  logic [DIV_W-1:0] cfg_div_int = '0;
  logic [3:0]       cfg_div_frac = '0;
  logic             cfg_ready, cfg_err, samp_tick, baud_tick_tx, baud_tick_rx;

  int n_cmp = 0, n_fail = 0, cyc = 0;
  bit mon = 1'b0;
  int q_samp[$], q_tx[$], q_rx[$], q_err[$];

  baud_gen_frac #(.DIV_W(DIV_W), .OSR(16), .DEF_INT(6), .DEF_FRAC(8)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_div_int(cfg_div_int), .cfg_div_frac(cfg_div_frac), .cfg_err(cfg_err),
    .rx_resync(rx_resync), .samp_tick(samp_tick), .baud_tick_tx(baud_tick_tx),
    .baud_tick_rx(baud_tick_rx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d, required finish", cyc);
    $fatal(1, "watchdog");
  end

  function automatic int qsize(input int s);
    case (s)
      0: return q_samp.size();
      1: return q_tx.size();
      2: return q_rx.size();
      default: return q_err.size();
    endcase
  endfunction

  task automatic qpop(input int s, output int t);
    case (s)
      0: t = q_samp.pop_front();
      1: t = q_tx.pop_front();
      2: t = q_rx.pop_front();
      default: t = q_err.pop_front();
    endcase
  endtask

  task automatic pop_cmp(input int s, input string name);
    int t;
    n_cmp++;
    if (qsize(s) == 0) begin
      n_fail++;
      $display("FAIL %s: pulse at cycle %0d, required none", name, cyc);
    end else begin
      qpop(s, t);
      if (t != cyc) begin
        n_fail++;
        $display("FAIL %s: pulse at cycle %0d, required cycle %0d", name, cyc, t);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon) begin
      if (samp_tick)    pop_cmp(0, "samp_tick");
      if (baud_tick_tx) pop_cmp(1, "baud_tick_tx");
      if (baud_tick_rx) pop_cmp(2, "baud_tick_rx");
      if (cfg_err)      pop_cmp(3, "cfg_err");
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d at cycle %0d", name, act, exp_v, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step();
  endtask

  // Expected strobes of a run: samp every period, tx at phase 15, rx at phase 7.
  // Default 6.5 divisor after reset gives gaps 6,7,6,7,... between strobes.
  task automatic push_run(input int t_first, input int t_end, input int tx0, input int rx0,
                          input bit frac_pat, input int per);
    int t;
    int n;
    t = t_first;
    n = 0;
    while (t <= t_end) begin
      q_samp.push_back(t);
      if ((tx0 + n) % 16 == 15) q_tx.push_back(t);
      if ((rx0 + n) % 16 == 7)  q_rx.push_back(t);
      t += frac_pat ? ((n % 2 == 0) ? 6 : 7) : per;
      n++;
    end
  endtask

  task automatic close_window(input string name);
    int t;
    @(negedge clk);
    #1;
    mon = 1'b0;
    for (int s = 0; s < 4; s++) begin
      n_cmp++;
      if (qsize(s) != 0) n_fail++;
      while (qsize(s) != 0) begin
        qpop(s, t);
        $display("FAIL %s stream %0d: no pulse seen, required one at cycle %0d", name, s, t);
      end
    end
    step();
  endtask

  task automatic do_reset(output int r);
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; rx_resync = 1'b0;
    step();
    check("reset_samp", samp_tick, 0);
    check("reset_ready", cfg_ready, 1);
    step();
    rst = 1'b0;
    r = cyc;
  endtask

  initial begin
    int r;
    int s;
    step();
    // Reset dominates en, cfg_valid and rx_resync.
    rst = 1'b1; en = 1'b1; cfg_valid = 1'b1; cfg_div_int = 1; rx_resync = 1'b1;
    step();
    check("rst_samp", samp_tick, 0);
    check("rst_tx", baud_tick_tx, 0);
    check("rst_rx", baud_tick_rx, 0);
    check("rst_err", cfg_err, 0);
    check("rst_ready", cfg_ready, 1);
    cfg_div_int = 10; cfg_div_frac = 3;
    step();
    check("rst_err2", cfg_err, 0);
    check("rst_ready2", cfg_ready, 1);
    rst = 1'b0; cfg_valid = 1'b0; rx_resync = 1'b0; en = 1'b1;
    r = cyc;

    // Default divisor: 16 strobes span 104 cycles with the fraction, 96 without.
    push_run(r + 6, r + 215, 0, 0, FRAC, 6);
    mon = 1'b1;
    step();
    check("default_ready", cfg_ready, 1);
    wait_to(r + 215);
    close_window("default_run");

    // Divisor switch mid-period, then an illegal divisor.
    do_reset(r);
    en = 1'b1;
    push_run(r + 6, r + 170, 0, 0, 1'b0, 10);
    q_err.push_back(r + 31);
    mon = 1'b1;
    wait_to(r + 2);
    cfg_valid = 1'b1; cfg_div_int = 10; cfg_div_frac = 0;
    step();
    cfg_valid = 1'b0;
    check("cap_ready_low", cfg_ready, 0);
    wait_to(r + 6);
    check("tick_cycle_ready_low", cfg_ready, 0);
    step();
    check("switch_ready_high", cfg_ready, 1);
    wait_to(r + 30);
    cfg_valid = 1'b1; cfg_div_int = 1; cfg_div_frac = 5;
    step();
    cfg_valid = 1'b0;
    check("err_ready_high", cfg_ready, 1);
    step();
    check("err_ready_high2", cfg_ready, 1);
    wait_to(r + 170);
    close_window("switch_run");

    // Config applied while disabled, RX realign, then en low for 20 cycles.
    do_reset(r);
    cfg_valid = 1'b1; cfg_div_int = 6; cfg_div_frac = 0;
    step();
    cfg_valid = 1'b0;
    check("idle_cap_ready_low", cfg_ready, 0);
    step();
    check("idle_apply_ready_high", cfg_ready, 1);
    en = 1'b1;
    s = cyc;
    push_run(s + 6, s + 60, 0, 0, 1'b0, 6);
    push_run(s + 68, s + 206, 10, 0, 1'b0, 6);
    push_run(s + 234, s + 330, 0, 0, 1'b0, 6);
    mon = 1'b1;
    wait_to(s + 62);
    rx_resync = 1'b1;
    step();
    rx_resync = 1'b0;
    wait_to(s + 208);
    en = 1'b0;
    wait_to(s + 220);
    check("en_low_samp", samp_tick, 0);
    wait_to(s + 228);
    en = 1'b1;
    wait_to(s + 330);
    close_window("resync_enable_run");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
